// File: rtl/scan_arbiter.sv
// -----------------------------------------------------------------------------
// scan_arbiter
//
// Purpose
//   Shares one byte-stream scanner between four requesters. One whole message
//   is in flight at a time. The arbiter grants a requester and forwards its
//   bytes to the scanner. It then passes the scanner's results back, tagged
//   with the owner, until the result marked "end" is accepted.
//
// Parameters
//   CNT_W      width of each per-requester completed-message counter
//   FIXED_PRIO 0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Optional feature
//   SCAN_ARB_STATS_EN  when defined, adds the oMsgCnt_0..3 outputs. Each one
//                      counts completed messages for its requester and wraps
//                      to 0 after reaching its maximum value.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   iValid_k/iEnd_k/iChar_k      requester k byte stream (k = 0..3)
//   oReady_k                     requester k byte accepted (with iValid_k)
//   sEn                          scanner enable; low in IDLE clears match history
//   sValid/sEnd/sChar, sReady    byte stream towards the scanner
//   sSID/sOffset/sResValid/sResEnd, sResReady   scanner result stream
//   oSID/oOffset/oTag/oValid/oEnd, iReady       tagged result output
//   oBusy                        arbiter is not IDLE
//   oGrant                       current or most recent owner
//   oDbgState                    raw FSM state (IDLE=0, STREAM=1, DRAIN=2)
//
// Handshake
//   Every stream moves a beat on a cycle where valid and ready are both high.
//   Valid does not wait for ready. The arbiter does not register any
//   pass-through path; it only steers the paths.
// -----------------------------------------------------------------------------
module scan_arbiter #(
  parameter int CNT_W      = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iValid_0,
  input  logic        iValid_1,
  input  logic        iValid_2,
  input  logic        iValid_3,
  input  logic        iEnd_0,
  input  logic        iEnd_1,
  input  logic        iEnd_2,
  input  logic        iEnd_3,
  input  logic [7:0]  iChar_0,
  input  logic [7:0]  iChar_1,
  input  logic [7:0]  iChar_2,
  input  logic [7:0]  iChar_3,
  output logic        oReady_0,
  output logic        oReady_1,
  output logic        oReady_2,
  output logic        oReady_3,
  output logic        sEn,
  output logic        sValid,
  output logic        sEnd,
  output logic [7:0]  sChar,
  input  logic        sReady,
  input  logic [31:0] sSID,
  input  logic [31:0] sOffset,
  input  logic        sResValid,
  input  logic        sResEnd,
  output logic        sResReady,
  output logic [31:0] oSID,
  output logic [31:0] oOffset,
  output logic [1:0]  oTag,
  output logic        oValid,
  output logic        oEnd,
  input  logic        iReady,
  output logic        oBusy,
  output logic [1:0]  oGrant,
  output logic [1:0]  oDbgState
`ifdef SCAN_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] oMsgCnt_0,
  output logic [CNT_W-1:0] oMsgCnt_1,
  output logic [CNT_W-1:0] oMsgCnt_2,
  output logic [CNT_W-1:0] oMsgCnt_3
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_grant;
  logic [1:0] r_last;

  logic [3:0] w_req;
  logic [3:0] w_end;
  logic       w_any;
  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_gvalid;
  logic       w_gend;
  logic [7:0] w_gchar;
  logic       w_done;
  logic [3:0] w_ready;

  assign w_req = {iValid_3, iValid_2, iValid_1, iValid_0};
  assign w_end = {iEnd_3, iEnd_2, iEnd_1, iEnd_0};
  assign w_any = |w_req;

  // The final result beat of a message is accepted downstream.
  assign w_done = (r_state == DRAIN) && sResValid && iReady && sResEnd;

  // Winner selection. Both loops go from the worst candidate to the best
  // one, so the last match written is the winner. In round-robin mode the
  // best candidate is the requester right after the last winner. The 2-bit
  // sum wraps modulo 4 by itself.
  always_comb begin
    w_winner = 2'd0;
    w_idx    = 2'd0;
    if (FIXED_PRIO != 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (w_req[i]) w_winner = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        w_idx = r_last + 2'(i) + 2'd1;
        if (w_req[w_idx]) w_winner = w_idx;
      end
    end
  end

  // Byte stream of the granted requester.
  always_comb begin
    w_gvalid = 1'b0;
    w_gend   = 1'b0;
    w_gchar  = 8'd0;
    case (r_grant)
      2'd0: begin w_gvalid = iValid_0; w_gend = iEnd_0; w_gchar = iChar_0; end
      2'd1: begin w_gvalid = iValid_1; w_gend = iEnd_1; w_gchar = iChar_1; end
      2'd2: begin w_gvalid = iValid_2; w_gend = iEnd_2; w_gchar = iChar_2; end
      default: begin w_gvalid = iValid_3; w_gend = iEnd_3; w_gchar = iChar_3; end
    endcase
  end

  // FSM next state and the steering of all pass-through paths.
  always_comb begin
    w_next    = r_state;
    sValid    = 1'b0;
    sEnd      = 1'b0;
    sChar     = 8'd0;
    w_ready   = 4'd0;
    sResReady = 1'b0;
    oValid    = 1'b0;
    oEnd      = 1'b0;
    oSID      = 32'd0;
    oOffset   = 32'd0;
    oTag      = 2'd0;
    case (r_state)
      IDLE: begin
        // This is the arbitration cycle only. No byte moves here.
        if (w_any) w_next = STREAM;
      end
      STREAM: begin
        sValid           = w_gvalid;
        sEnd             = w_gend;
        sChar            = w_gchar;
        w_ready[r_grant] = sReady;
        // Gaps in iValid keep the grant. Only the end beat releases it.
        if (w_gvalid && sReady && w_gend) w_next = DRAIN;
      end
      DRAIN: begin
        oValid    = sResValid;
        oEnd      = sResEnd;
        oSID      = sSID;
        oOffset   = sOffset;
        oTag      = r_grant;
        sResReady = iReady;
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= 2'd0;
      r_last  <= 2'd3;  // the first search after reset starts at requester 0
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) r_grant <= w_winner;
      if (w_done) r_last <= r_grant;
    end
  end

  assign oReady_0  = w_ready[0];
  assign oReady_1  = w_ready[1];
  assign oReady_2  = w_ready[2];
  assign oReady_3  = w_ready[3];
  assign oBusy     = (r_state != IDLE);
  assign sEn       = (r_state != IDLE);
  assign oGrant    = r_grant;
  assign oDbgState = r_state;

`ifdef SCAN_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else if (w_done) begin
      r_cnt[r_grant] <= r_cnt[r_grant] + CNT_W'(1);
    end
  end

  assign oMsgCnt_0 = r_cnt[0];
  assign oMsgCnt_1 = r_cnt[1];
  assign oMsgCnt_2 = r_cnt[2];
  assign oMsgCnt_3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_scan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_scan_arbiter
//
// Instance 0 is a round-robin arbiter and instance 1 is a fixed-priority
// arbiter. Both are driven from the same requester and scanner stimulus.
// The reference model describes the behaviour as transactions:
//   - each arbiter is either free, owned with bytes still flowing, or owned
//     and returning results;
//   - a free arbiter picks one requester from the set that is asking;
//   - ownership ends with the accepted end byte and the accepted end result.
// Inputs change on the falling edge. Outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_scan_arbiter;

  localparam int TB_CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- stimulus ----------------
  logic [3:0]  iv;
  logic [3:0]  ie;
  logic [7:0]  ic [4];
  logic        s_ready;
  logic        s_res_valid;
  logic        s_res_end;
  logic        i_ready;
  logic [31:0] s_sid;
  logic [31:0] s_off;

  // ---------------- DUT outputs, index = instance ----------------
  logic        ordy_o   [2][4];
  logic        sen_o    [2];
  logic        svalid_o [2];
  logic        send_o   [2];
  logic [7:0]  schar_o  [2];
  logic        sresrdy_o[2];
  logic [31:0] osid_o   [2];
  logic [31:0] ooff_o   [2];
  logic [1:0]  otag_o   [2];
  logic        ovalid_o [2];
  logic        oend_o   [2];
  logic        obusy_o  [2];
  logic [1:0]  ogrant_o [2];
  logic [1:0]  odbg_o   [2];
`ifdef SCAN_ARB_STATS_EN
  logic [TB_CNT_W-1:0] cnt_o [2][4];
`endif

  for (genvar d = 0; d < 2; d++) begin : g_dut
    scan_arbiter #(.CNT_W(TB_CNT_W), .FIXED_PRIO(d)) dut (
      .clk(clk), .reset_n(reset_n),
      .iValid_0(iv[0]), .iValid_1(iv[1]), .iValid_2(iv[2]), .iValid_3(iv[3]),
      .iEnd_0(ie[0]), .iEnd_1(ie[1]), .iEnd_2(ie[2]), .iEnd_3(ie[3]),
      .iChar_0(ic[0]), .iChar_1(ic[1]), .iChar_2(ic[2]), .iChar_3(ic[3]),
      .oReady_0(ordy_o[d][0]), .oReady_1(ordy_o[d][1]),
      .oReady_2(ordy_o[d][2]), .oReady_3(ordy_o[d][3]),
      .sEn(sen_o[d]), .sValid(svalid_o[d]), .sEnd(send_o[d]), .sChar(schar_o[d]),
      .sReady(s_ready),
      .sSID(s_sid), .sOffset(s_off), .sResValid(s_res_valid), .sResEnd(s_res_end),
      .sResReady(sresrdy_o[d]),
      .oSID(osid_o[d]), .oOffset(ooff_o[d]), .oTag(otag_o[d]),
      .oValid(ovalid_o[d]), .oEnd(oend_o[d]), .iReady(i_ready),
      .oBusy(obusy_o[d]), .oGrant(ogrant_o[d]), .oDbgState(odbg_o[d])
`ifdef SCAN_ARB_STATS_EN
      ,
      .oMsgCnt_0(cnt_o[d][0]), .oMsgCnt_1(cnt_o[d][1]),
      .oMsgCnt_2(cnt_o[d][2]), .oMsgCnt_3(cnt_o[d][3])
`endif
    );
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected grant order for the directed all-requesters run.
  logic [1:0] exp_q    [$];
  logic [1:0] exp_fp_q [$];
  bit         track_en;
  bit         prev_busy [2];

  // ---------------- reference model ----------------
  // mode: 0 free, 1 owner sending bytes, 2 owner receiving results
  int m_mode  [2];
  int m_owner [2];
  int m_last  [2];
  int m_cnt   [2][4];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d]  = 0;
      m_owner[d] = 0;
      m_last[d]  = 3;
      for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
      prev_busy[d] = 1'b0;
    end
  endtask

  function automatic int pick(input int d, input logic [3:0] req, input int last);
    int w;
    w = -1;
    if (d == 1) begin
      for (int k = 0; k < 4; k++) if (req[k] && w < 0) w = k;
    end else begin
      for (int off = 1; off <= 4; off++) if (req[(last + off) % 4] && w < 0) w = (last + off) % 4;
    end
    return w;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int g;
      g = m_owner[d];
      if (m_mode[d] == 0) begin
        if (iv != 4'd0) begin
          m_owner[d] = pick(d, iv, m_last[d]);
          m_mode[d]  = 1;
        end
      end else if (m_mode[d] == 1) begin
        if (iv[g] && s_ready && ie[g]) m_mode[d] = 2;
      end else begin
        if (s_res_valid && i_ready && s_res_end) begin
          m_mode[d]     = 0;
          m_last[d]     = g;
          m_cnt[d][g]   = (m_cnt[d][g] + 1) % (1 << TB_CNT_W);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int g;
      bit in_s, in_d;
      g    = m_owner[d];
      in_s = (m_mode[d] == 1);
      in_d = (m_mode[d] == 2);
      chk($sformatf("d%0d_busy", d),   64'(obusy_o[d]),   64'(m_mode[d] != 0));
      chk($sformatf("d%0d_sen", d),    64'(sen_o[d]),     64'(m_mode[d] != 0));
      chk($sformatf("d%0d_grant", d),  64'(ogrant_o[d]),  64'(g));
      chk($sformatf("d%0d_svalid", d), 64'(svalid_o[d]),  64'(in_s ? iv[g] : 1'b0));
      for (int k = 0; k < 4; k++)
        chk($sformatf("d%0d_oready%0d", d, k), 64'(ordy_o[d][k]), 64'((in_s && k == g) ? s_ready : 1'b0));
      chk($sformatf("d%0d_sresready", d), 64'(sresrdy_o[d]), 64'(in_d ? i_ready : 1'b0));
      chk($sformatf("d%0d_ovalid", d),    64'(ovalid_o[d]),  64'(in_d ? s_res_valid : 1'b0));
      if (in_s) begin
        chk($sformatf("d%0d_schar", d), 64'(schar_o[d]), 64'(ic[g]));
        chk($sformatf("d%0d_send", d),  64'(send_o[d]),  64'(ie[g]));
      end
      if (in_d) begin
        chk($sformatf("d%0d_osid", d), 64'(osid_o[d]), 64'(s_sid));
        chk($sformatf("d%0d_ooff", d), 64'(ooff_o[d]), 64'(s_off));
        chk($sformatf("d%0d_oend", d), 64'(oend_o[d]), 64'(s_res_end));
        chk($sformatf("d%0d_otag", d), 64'(otag_o[d]), 64'(g));
      end
`ifdef SCAN_ARB_STATS_EN
      for (int k = 0; k < 4; k++)
        chk($sformatf("d%0d_cnt%0d", d, k), 64'(cnt_o[d][k]), 64'(m_cnt[d][k]));
`endif
      // Each new grant in the directed run must follow the expected order.
      if (track_en && !prev_busy[d] && obusy_o[d]) begin
        if (d == 0) begin
          if (exp_q.size() > 0) chk("d0_rr_order", 64'(ogrant_o[0]), 64'(exp_q.pop_front()));
          else chk("d0_rr_order_extra", 64'(1), 64'(0));
        end else begin
          if (exp_fp_q.size() > 0) chk("d1_fp_order", 64'(ogrant_o[1]), 64'(exp_fp_q.pop_front()));
          else chk("d1_fp_order_extra", 64'(1), 64'(0));
        end
      end
      prev_busy[d] = obusy_o[d];
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge after the inputs are set. Checks, then advances.
  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(negedge clk);
  endtask

  // Pull reset low and check the outputs while it is still low. Release at
  // the next falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_busy", d),   64'(obusy_o[d]),   64'(0));
      chk($sformatf("d%0d_rst_sen", d),    64'(sen_o[d]),     64'(0));
      chk($sformatf("d%0d_rst_grant", d),  64'(ogrant_o[d]),  64'(0));
      chk($sformatf("d%0d_rst_svalid", d), 64'(svalid_o[d]),  64'(0));
      chk($sformatf("d%0d_rst_send", d),   64'(send_o[d]),    64'(0));
      chk($sformatf("d%0d_rst_sresrdy", d), 64'(sresrdy_o[d]), 64'(0));
      chk($sformatf("d%0d_rst_ovalid", d), 64'(ovalid_o[d]),  64'(0));
      chk($sformatf("d%0d_rst_oend", d),   64'(oend_o[d]),    64'(0));
      chk($sformatf("d%0d_rst_otag", d),   64'(otag_o[d]),    64'(0));
      for (int k = 0; k < 4; k++)
        chk($sformatf("d%0d_rst_oready%0d", d, k), 64'(ordy_o[d][k]), 64'(0));
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic idle_inputs();
    iv = 4'd0; ie = 4'd0;
    for (int k = 0; k < 4; k++) ic[k] = 8'd0;
    s_ready = 1'b0; s_res_valid = 1'b0; s_res_end = 1'b0; i_ready = 1'b0;
    s_sid = 32'd0; s_off = 32'd0;
  endtask

  task automatic random_inputs();
    for (int k = 0; k < 4; k++) begin
      iv[k] = ($urandom_range(0, 9) < 7);
      ie[k] = ($urandom_range(0, 3) == 0);
      ic[k] = 8'($urandom_range(0, 255));
    end
    s_ready     = ($urandom_range(0, 3) != 0);
    s_res_valid = ($urandom_range(0, 9) < 6);
    s_res_end   = ($urandom_range(0, 2) == 0);
    i_ready     = ($urandom_range(0, 9) < 7);
    s_sid       = $urandom;
    s_off       = $urandom;
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] msg [5];

  initial begin
    reset_n  = 1'b0;
    track_en = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Requester 0 sends a 5-byte message. The scanner returns one end result.
    msg[0] = 8'h0a; msg[1] = 8'h0b; msg[2] = 8'h0c; msg[3] = 8'h0d; msg[4] = 8'h55;
    s_ready = 1'b1;
    iv[0] = 1'b1; ic[0] = msg[0];
    cycle();                                   // arbitration
    for (int b = 0; b < 5; b++) begin
      ic[0] = msg[b]; ie[0] = (b == 4);
      cycle();
    end
    iv[0] = 1'b0; ie[0] = 1'b0;
    s_res_valid = 1'b1; s_res_end = 1'b1; i_ready = 1'b1;
    s_sid = 32'h0000_0155; s_off = 32'd4;
    cycle();
    idle_inputs();
    cycle();                                   // back to free

    // Requester 2 is reset partway through its message. The result stall
    // path is covered by the random phase.
    s_ready = 1'b1;
    iv[2] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      ic[2] = 8'(8'h20 + b);
      cycle();
    end
    do_reset();

    // All requesters ask continuously and send 1-byte messages.
    idle_inputs();
    iv = 4'hf; ie = 4'hf; s_ready = 1'b1;
    s_res_valid = 1'b1; s_res_end = 1'b1; i_ready = 1'b1;
    s_sid = 32'h0000_00aa;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int i = 0; i < 5; i++) exp_fp_q.push_back(2'd0);
    track_en = 1'b1;
    for (int c = 0; c < 15; c++) cycle();
    track_en = 1'b0;
    chk("rr_order_drained", 64'(exp_q.size()), 64'(0));
    chk("fp_order_drained", 64'(exp_fp_q.size()), 64'(0));
    idle_inputs();
    cycle();
    cycle();

    // Random traffic with an occasional asynchronous reset.
    for (int c = 0; c < 4000; c++) begin
      random_inputs();
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/scan_arbiter.md
SCAN_ARBITER -- requirements
Module: scan_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each per-requester message counter.
REQ-002 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = fixed priority, lowest index wins.
REQ-003 SHALL have port clk  in  1  sole clock; all flops rise-edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports iValid_k / iEnd_k (k=0..3)  in  1 each  requester k byte valid / last byte of message.
REQ-006 SHALL have ports iChar_k (k=0..3)  in  8 each  requester k byte.
REQ-007 SHALL have ports oReady_k (k=0..3)  out  1 each  requester k byte accepted when high with iValid_k.
REQ-008 SHALL have ports sEn, sValid, sEnd  out  1 each; sChar  out  8; sReady  in  1  (scanner input side).
REQ-009 SHALL have ports sSID, sOffset  in  32 each; sResValid, sResEnd  in  1 each; sResReady  out  1  (scanner result side).
REQ-010 SHALL have ports oSID, oOffset  out  32 each; oTag  out  2; oValid, oEnd  out  1 each; iReady  in  1  (tagged result output).
REQ-011 SHALL have ports oBusy  out  1 (state != IDLE) and oGrant  out  2 (current owner).

Function
REQ-012 SHALL implement FSM states IDLE, STREAM, DRAIN; one scanner message in flight at any time.
REQ-013 IDLE: if any iValid_k high, SHALL register winner into oGrant and enter STREAM next cycle; no byte forwarded in the arbitration cycle (1-cycle grant latency).
REQ-014 Round-robin SHALL search from (last winner + 1) mod 4 upward; after reset the search starts at requester 0.
REQ-015 STREAM: sValid/sChar/sEnd SHALL combinationally equal the granted requester's iValid/iChar/iEnd; oReady_grant = sReady; all other oReady_k = 0.
REQ-016 STREAM: beat with sValid & sReady & sEnd SHALL transition to DRAIN next cycle; no further bytes forwarded.
REQ-017 Granted requester deasserting iValid mid-message SHALL NOT release grant; FSM waits in STREAM indefinitely.
REQ-018 DRAIN: oSID=sSID, oOffset=sOffset, oValid=sResValid, oEnd=sResEnd, sResReady=iReady, oTag=oGrant, all combinational.
REQ-019 DRAIN: beat with sResValid & iReady & sResEnd SHALL return to IDLE next cycle and record last winner.
REQ-020 Outside DRAIN: oValid=0, sResReady=0; outside STREAM: sValid=0, all oReady_k=0.
REQ-021 sEn SHALL be 1 in STREAM and DRAIN, 0 in IDLE (clears scanner match history between messages).
REQ-022 Requests arriving during STREAM/DRAIN SHALL be held off (oReady=0) and arbitrated only on the next IDLE cycle.
REQ-023 Single-byte message (iEnd with first byte) SHALL go IDLE->STREAM->DRAIN in consecutive cycles.
REQ-024 iReady low in DRAIN SHALL stall; result outputs hold scanner values unchanged.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, oGrant=0, last winner=3 (search starts at 0), all counters=0.
REQ-026 During/after reset all oReady_k, sValid, sEnd, sEn, sResReady, oValid, oEnd, oBusy SHALL be 0; oTag=0.
REQ-027 Reset mid-STREAM or mid-DRAIN SHALL abandon the message; no partial result emitted afterward.

Configuration
REQ-028 Macro SCAN_ARB_STATS_EN defined: SHALL add outputs oMsgCnt_k (k=0..3, CNT_W each), incremented on each REQ-019 completion for owner k, wrapping at 2^CNT_W-1 -> 0.
REQ-029 Macro SCAN_ARB_STATS_EN undefined: counters and oMsgCnt_k ports SHALL be absent; all other behaviour identical.

Verification
REQ-030 Req0 sends 5 bytes 0x0a,0x0b,0x0c,0x0d,0x55(end), scanner returns SID 0x0155 end -> oTag=0, oSID=0x00000155, oEnd=1, FSM back to IDLE.
REQ-031 All four iValid high continuously, 1-byte messages -> grants 0,1,2,3,0 in order; FIXED_PRIO=1 -> grants 0,0,0.
REQ-032 Req2 streaming, req1 raises iValid -> oReady_1=0 until req2 result with end accepted; req1 granted next.
REQ-033 DRAIN with 2 results, iReady low 4 cycles -> oValid held, first SID stable, second result then end; tag constant.
REQ-034 reset_n low for 1 cycle mid-STREAM byte 3 -> outputs zero immediately, next grant goes to requester 0.
REQ-035 SCAN_ARB_STATS_EN, CNT_W=2, req3 sends 5 messages -> oMsgCnt_3 sequence 1,2,3,0,1.
